// File: rtl/ibex_pkg.sv
// Shared types for the mul/div issue controller: operator and state encodings
// plus the request bundle that is latched on accept and used as the cache key.
package ibex_pkg;

    typedef enum logic [1:0] {
        MD_OP_MULL = 2'd0,
        MD_OP_MULH = 2'd1,
        MD_OP_DIV  = 2'd2,
        MD_OP_REM  = 2'd3
    } md_op_e;

    typedef enum logic [1:0] {
        MD_ISSUE_IDLE  = 2'd0,
        MD_ISSUE_RUN   = 2'd1,
        MD_ISSUE_DRAIN = 2'd2,
        MD_ISSUE_DONE  = 2'd3
    } md_issue_state_e;

    typedef struct packed {
        md_op_e      op;
        logic [1:0]  signed_mode;
        logic [31:0] op_a;
        logic [31:0] op_b;
    } md_req_t;

    function automatic logic md_op_is_div(input md_op_e op);
        return op[1];
    endfunction

endpackage

// File: rtl/ibex_md_result_cache.sv
// Single-entry cache of the last completed mul/div op (key + result), used only
// when IBEX_MD_RESULT_CACHE_EN is defined.
module ibex_md_result_cache
    import ibex_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        flush_i,
    input  md_req_t     lookup_i,
    input  logic        upd_i,
    input  md_req_t     upd_req_i,
    input  logic [31:0] upd_result_i,
    output logic        hit_o,
    output logic [31:0] result_o
);

    logic        valid_q;
    md_req_t     key_q;
    logic [31:0] res_q;

    // Flush wins over a same-cycle update so a killed context never seeds a hit.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
        end else if (flush_i) begin
            valid_q <= 1'b0;
        end else if (upd_i) begin
            valid_q <= 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            key_q <= '0;
            res_q <= '0;
        end else if (upd_i) begin
            key_q <= upd_req_i;
            res_q <= upd_result_i;
        end
    end

    assign hit_o    = valid_q & (key_q == lookup_i);
    assign result_o = res_q;

endmodule

// File: rtl/ibex_md_issue_ctrl.sv
// Execute-stage issue controller in front of the multdiv unit. Holds enables until
// valid, drains killed ops (multdiv has no clear). Optional: IBEX_MD_RESULT_CACHE_EN.
module ibex_md_issue_ctrl
    import ibex_pkg::*;
#(
    parameter bit RESULT_REG = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        md_req_i,
    input  logic [1:0]  md_operator_i,
    input  logic [1:0]  md_signed_mode_i,
    input  logic [31:0] md_op_a_i,
    input  logic [31:0] md_op_b_i,
    input  logic        flush_i,
    output logic        md_ready_o,
    output logic        md_busy_o,
    output logic [31:0] md_result_o,
    output logic        md_result_valid_o,
    output logic        mult_en_o,
    output logic        div_en_o,
    output logic [1:0]  operator_o,
    output logic [1:0]  signed_mode_o,
    output logic [31:0] op_a_o,
    output logic [31:0] op_b_o,
    input  logic [31:0] multdiv_result_i,
    input  logic        multdiv_valid_i
);

    md_issue_state_e state_q, state_d;
    md_req_t         req_q, req_d, in_req;
    logic [31:0]     result_q, result_d;
    logic            cache_hit;
    logic [31:0]     cache_result;
    logic            accept;

    assign in_req = '{op:          md_op_e'(md_operator_i),
                      signed_mode: md_signed_mode_i,
                      op_a:        md_op_a_i,
                      op_b:        md_op_b_i};

`ifdef IBEX_MD_RESULT_CACHE_EN
    logic cache_upd;

    // Only a genuine completion (valid without flush in RUN) refreshes the entry.
    assign cache_upd = (state_q == MD_ISSUE_RUN) & multdiv_valid_i & ~flush_i;

    ibex_md_result_cache u_result_cache (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .flush_i      (flush_i),
        .lookup_i     (in_req),
        .upd_i        (cache_upd),
        .upd_req_i    (req_q),
        .upd_result_i (multdiv_result_i),
        .hit_o        (cache_hit),
        .result_o     (cache_result)
    );
`else
    assign cache_hit    = 1'b0;
    assign cache_result = '0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= MD_ISSUE_IDLE;
            req_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            req_q    <= req_d;
            result_q <= result_d;
        end
    end

    always_comb begin
        state_d           = state_q;
        req_d             = req_q;
        result_d          = result_q;
        accept            = 1'b0;
        md_ready_o        = 1'b0;
        mult_en_o         = 1'b0;
        div_en_o          = 1'b0;
        md_result_valid_o = 1'b0;
        md_result_o       = result_q;

        unique case (state_q)
            MD_ISSUE_IDLE: begin
                accept     = md_req_i & ~flush_i;
                md_ready_o = accept;
                if (accept) begin
                    req_d = in_req;
                    if (cache_hit) begin
                        result_d = cache_result;
                        state_d  = MD_ISSUE_DONE;
                    end else begin
                        state_d  = MD_ISSUE_RUN;
                    end
                end
            end

            MD_ISSUE_RUN: begin
                mult_en_o = ~md_op_is_div(req_q.op);
                div_en_o  = md_op_is_div(req_q.op);
                if (multdiv_valid_i) begin
                    // The unit is already idle again, so a same-cycle flush needs no drain.
                    state_d = MD_ISSUE_IDLE;
                    if (!flush_i) begin
                        result_d = multdiv_result_i;
                        if (RESULT_REG) begin
                            state_d = MD_ISSUE_DONE;
                        end else begin
                            md_result_valid_o = 1'b1;
                            md_result_o       = multdiv_result_i;
                        end
                    end
                end else if (flush_i) begin
                    state_d = MD_ISSUE_DRAIN;
                end
            end

            MD_ISSUE_DRAIN: begin
                mult_en_o = ~md_op_is_div(req_q.op);
                div_en_o  = md_op_is_div(req_q.op);
                if (multdiv_valid_i) begin
                    state_d = MD_ISSUE_IDLE;
                end
            end

            MD_ISSUE_DONE: begin
                md_result_valid_o = ~flush_i;
                state_d           = MD_ISSUE_IDLE;
            end

            default: state_d = MD_ISSUE_IDLE;
        endcase
    end

    assign md_busy_o     = (state_q != MD_ISSUE_IDLE);
    assign operator_o    = req_q.op;
    assign signed_mode_o = req_q.signed_mode;
    assign op_a_o        = req_q.op_a;
    assign op_b_o        = req_q.op_b;

endmodule

// File: tb/tb_ibex_md_issue_ctrl.sv
// Directed + random bench for ibex_md_issue_ctrl with a behavioural multdiv stand-in.
module tb_ibex_md_issue_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        md_req_i;
    logic [1:0]  md_operator_i;
    logic [1:0]  md_signed_mode_i;
    logic [31:0] md_op_a_i;
    logic [31:0] md_op_b_i;
    logic        flush_i;
    logic        md_ready_o;
    logic        md_busy_o;
    logic [31:0] md_result_o;
    logic        md_result_valid_o;
    logic        mult_en_o;
    logic        div_en_o;
    logic [1:0]  operator_o;
    logic [1:0]  signed_mode_o;
    logic [31:0] op_a_o;
    logic [31:0] op_b_o;
    logic [31:0] multdiv_result_i;
    logic        multdiv_valid_i;

    int          tests = 0;
    int          fails = 0;
    logic [31:0] hold_res = '0;
    logic [5:0]  md_cnt;

    always #5 clk_i = ~clk_i;

    ibex_md_issue_ctrl dut (
        .clk_i             (clk_i),
        .rst_ni            (rst_ni),
        .md_req_i          (md_req_i),
        .md_operator_i     (md_operator_i),
        .md_signed_mode_i  (md_signed_mode_i),
        .md_op_a_i         (md_op_a_i),
        .md_op_b_i         (md_op_b_i),
        .flush_i           (flush_i),
        .md_ready_o        (md_ready_o),
        .md_busy_o         (md_busy_o),
        .md_result_o       (md_result_o),
        .md_result_valid_o (md_result_valid_o),
        .mult_en_o         (mult_en_o),
        .div_en_o          (div_en_o),
        .operator_o        (operator_o),
        .signed_mode_o     (signed_mode_o),
        .op_a_o            (op_a_o),
        .op_b_o            (op_b_o),
        .multdiv_result_i  (multdiv_result_i),
        .multdiv_valid_i   (multdiv_valid_i)
    );

    // Arithmetic reference for the four RISC-V M operations.
    function automatic logic [31:0] md_ref(input logic [1:0] op, input logic [1:0] sm,
                                           input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ea, eb, p;
        int sa, sb;
        ea = sm[0] ? {{32{a[31]}}, a} : {32'b0, a};
        eb = sm[1] ? {{32{b[31]}}, b} : {32'b0, b};
        p  = ea * eb;
        sa = $signed(a);
        sb = $signed(b);
        case (op)
            2'd0: return p[31:0];
            2'd1: return p[63:32];
            default: begin
                if (b == 32'd0) return (op == 2'd2) ? 32'hFFFF_FFFF : a;
                if (sm == 2'b11) begin
                    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
                        return (op == 2'd2) ? a : 32'd0;
                    return (op == 2'd2) ? 32'(sa / sb) : 32'(sa % sb);
                end
                return (op == 2'd2) ? a / b : a % b;
            end
        endcase
    endfunction

    function automatic int lat_of(input logic [1:0] op, input logic [31:0] b);
        if (op == 2'd0) return 3;
        if (op == 2'd1) return 4;
        return (b == 32'd0) ? 2 : 37;
    endfunction

    // Multdiv stand-in: raises valid on the last enabled cycle of the op's latency.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)                           md_cnt <= '0;
        else if (mult_en_o | div_en_o)         md_cnt <= multdiv_valid_i ? 6'd0 : md_cnt + 6'd1;
        else                                   md_cnt <= '0;
    end

    always_comb begin
        multdiv_valid_i  = (mult_en_o | div_en_o) &&
                           (int'(md_cnt) == lat_of(operator_o, op_b_o) - 1);
        multdiv_result_i = md_ref(operator_o, signed_mode_o, op_a_o, op_b_o);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one op, optionally flush at cycle flush_cyc after accept (0 = never).
    task automatic run_op(input string tag, input logic [1:0] op, input logic [1:0] sm,
                          input logic [31:0] a, input logic [31:0] b, input int flush_cyc,
                          input int exp_en, input bit exp_pulse, input bit exp_cap);
        logic [31:0] exp_res, pres;
        int en, bad, pulses, c;
        bit done;
        exp_res = md_ref(op, sm, a, b);
        en = 0; bad = 0; pulses = 0; c = 1; done = 0; pres = '0;
        @(posedge clk_i); #1;
        md_req_i = 1'b1; md_operator_i = op; md_signed_mode_i = sm;
        md_op_a_i = a; md_op_b_i = b; flush_i = 1'b0;
        @(negedge clk_i);
        chk({tag, ".ready"}, 32'(md_ready_o), 32'd1);
        @(posedge clk_i); #1;
        // Garbage on the inputs with req still high: must be neither accepted nor latched.
        md_op_a_i = $urandom; md_op_b_i = $urandom;
        md_operator_i = 2'($urandom); md_signed_mode_i = 2'($urandom);
        while (!done && c <= 80) begin
            flush_i = (c == flush_cyc);
            @(negedge clk_i);
            if (c == 1) begin
                chk({tag, ".busy_noaccept"}, 32'(md_ready_o), 32'd0);
                chk({tag, ".op_a"}, op_a_o, a);
                chk({tag, ".op_b"}, op_b_o, b);
                chk({tag, ".opsm"}, {28'd0, operator_o, signed_mode_o}, {28'd0, op, sm});
            end
            if (mult_en_o | div_en_o) en++;
            if ((mult_en_o & op[1]) | (div_en_o & ~op[1])) bad++;
            if (md_result_valid_o) begin
                pulses++;
                pres = md_result_o;
            end
            if (!md_busy_o) done = 1'b1;
            @(posedge clk_i); #1;
            md_req_i = 1'b0; flush_i = 1'b0;
            c++;
        end
        chk({tag, ".finished"}, 32'(done), 32'd1);
        chk({tag, ".en_cycles"}, en, exp_en);
        chk({tag, ".wrong_en"}, bad, 0);
        chk({tag, ".pulses"}, pulses, 32'(exp_pulse));
        if (exp_pulse) chk({tag, ".result"}, pres, exp_res);
        if (exp_cap) hold_res = exp_res;
        chk({tag, ".hold"}, md_result_o, hold_res);
    endtask

    initial begin
        int hit_en;
        logic [1:0]  rop, rsm;
        logic [31:0] ra, rb;
        rst_ni = 1'b0; md_req_i = 1'b0; md_operator_i = '0; md_signed_mode_i = '0;
        md_op_a_i = '0; md_op_b_i = '0; flush_i = 1'b0;
        #12;
        chk("rst.busy", 32'(md_busy_o), 32'd0);
        chk("rst.valid_en", {29'd0, md_result_valid_o, mult_en_o, div_en_o}, 32'd0);
        chk("rst.result", md_result_o, 32'd0);
        chk("rst.regs", {26'd0, operator_o, signed_mode_o, 2'b00} | op_a_o | op_b_o, 32'd0);
        @(negedge clk_i); rst_ni = 1'b1;

`ifdef IBEX_MD_RESULT_CACHE_EN
        hit_en = 0;
`else
        hit_en = 3;
`endif
        run_op("mull",    2'd0, 2'b00, 32'd7, 32'd6, 0, 3, 1'b1, 1'b1);
        run_op("mull_rep", 2'd0, 2'b00, 32'd7, 32'd6, 0, hit_en, 1'b1, 1'b1);

        // Flush while idle with a request pending: not accepted, nothing starts.
        @(posedge clk_i); #1;
        md_req_i = 1'b1; md_operator_i = 2'd0; md_op_a_i = 32'd7; md_op_b_i = 32'd6;
        md_signed_mode_i = 2'b00; flush_i = 1'b1;
        @(negedge clk_i);
        chk("idle_flush.ready", 32'(md_ready_o), 32'd0);
        @(posedge clk_i); #1;
        md_req_i = 1'b0; flush_i = 1'b0;
        @(negedge clk_i);
        chk("idle_flush.busy", 32'(md_busy_o), 32'd0);

        run_op("mull_postflush", 2'd0, 2'b00, 32'd7, 32'd6, 0, 3, 1'b1, 1'b1);
        run_op("mulh",    2'd1, 2'b11, 32'h8000_0000, 32'd2, 0, 4, 1'b1, 1'b1);
        run_op("div",     2'd2, 2'b11, 32'hFFFF_FFF9, 32'd2, 0, 37, 1'b1, 1'b1);
        run_op("rem",     2'd3, 2'b11, 32'hFFFF_FFF9, 32'd2, 0, 37, 1'b1, 1'b1);
        run_op("div0",    2'd2, 2'b11, 32'd5, 32'd0, 0, 2, 1'b1, 1'b1);
        run_op("rem0",    2'd3, 2'b11, 32'd5, 32'd0, 0, 2, 1'b1, 1'b1);
        run_op("div_ovf", 2'd2, 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 0, 37, 1'b1, 1'b1);
        // Flush mid-divide: drained, enable held to valid, no pulse, old result kept.
        run_op("drain",   2'd2, 2'b00, 32'd100, 32'd7, 10, 37, 1'b0, 1'b0);
        run_op("after_drain", 2'd0, 2'b00, 32'd123, 32'd456, 0, 3, 1'b1, 1'b1);
        // Flush coincident with valid: result dropped, straight back to idle.
        run_op("flush_valid", 2'd1, 2'b00, 32'hDEAD_BEEF, 32'h1234_5678, 4, 4, 1'b0, 1'b0);
        // Flush in DONE: pulse suppressed, result already captured.
        run_op("flush_done", 2'd0, 2'b00, 32'd9, 32'd11, 4, 3, 1'b0, 1'b1);

        for (int i = 0; i < 20; i++) begin
            rop = 2'($urandom);
            rsm = rop[1] ? (($urandom_range(0, 1) == 1) ? 2'b11 : 2'b00) : 2'($urandom);
            ra  = $urandom;
            rb  = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
            run_op("rand", rop, rsm, ra, rb, 0, lat_of(rop, rb), 1'b1, 1'b1);
        end

        // Asynchronous reset in the middle of a divide.
        @(posedge clk_i); #1;
        md_req_i = 1'b1; md_operator_i = 2'd2; md_signed_mode_i = 2'b00;
        md_op_a_i = 32'd77; md_op_b_i = 32'd3;
        @(posedge clk_i); #1;
        md_req_i = 1'b0;
        repeat (5) @(posedge clk_i);
        #2 rst_ni = 1'b0;
        #1;
        chk("midrst.busy", 32'(md_busy_o), 32'd0);
        chk("midrst.en", {30'd0, mult_en_o, div_en_o}, 32'd0);
        chk("midrst.result", md_result_o, 32'd0);
        chk("midrst.op_a", op_a_o, 32'd0);
        @(negedge clk_i); rst_ni = 1'b1;
        hold_res = '0;
        run_op("post_rst", 2'd0, 2'b01, 32'hFFFF_FFFF, 32'd3, 0, 3, 1'b1, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
